// File: rtl/conv_pkg.sv
// conv_pkg: pixel, position, window and column types shared by the convolution pipeline.
package conv_pkg;
   localparam int PIXEL_W      = 8;
   localparam int KERNEL_POS_W = 8;
   localparam int WINDOW_W     = 25 * PIXEL_W;
   typedef logic [PIXEL_W-1:0] pixel_t;
   typedef struct packed { logic w2, w1, e2, e1, n2, n1, s2, s1; } kernel_pos_t;
   typedef enum logic { PAD_ZERO, PAD_REPLICATE } pad_mode_t;
   typedef pixel_t [4:0][4:0] window_t;
   typedef struct packed { logic valid; kernel_pos_t pos; pixel_t [4:0] data; } col_t;
   typedef enum logic [1:0] { IDLE, FILL, RUN, FLUSH } win_state_t;
   function automatic pixel_t pad_px(pad_mode_t mode, logic pad, pixel_t keep, pixel_t src);
      return pad ? (mode == PAD_ZERO ? '0 : src) : keep;
   endfunction
endpackage

// File: rtl/conv_kernel_win_pad.sv
// conv_kernel_win_pad: fills out-of-frame rows, then columns, of a raw 5x5 window.
module conv_kernel_win_pad
   import conv_pkg::*;
#(
   parameter pad_mode_t PAD_MODE = PAD_ZERO
) (
   input  logic [WINDOW_W-1:0]     raw_i,
   input  logic [KERNEL_POS_W-1:0] pos_i,
   output logic [WINDOW_W-1:0]     win_o
);
   window_t raw, rows, win;
   kernel_pos_t p;
   always_comb begin
      raw = raw_i;
      p = pos_i;
      rows = raw;
      for (int k = 0; k < 5; k++) begin
         rows[0][k] = pad_px(PAD_MODE, p.n2 | p.n1, raw[0][k], p.n2 ? raw[2][k] : raw[1][k]);
         rows[1][k] = pad_px(PAD_MODE, p.n2, raw[1][k], raw[2][k]);
         rows[3][k] = pad_px(PAD_MODE, p.s2, raw[3][k], raw[2][k]);
         rows[4][k] = pad_px(PAD_MODE, p.s2 | p.s1, raw[4][k], p.s2 ? raw[2][k] : raw[3][k]);
      end
      // columns read the row-padded window so corners replicate correctly
      win = rows;
      for (int k = 0; k < 5; k++) begin
         win[k][0] = pad_px(PAD_MODE, p.w2 | p.w1, rows[k][0], p.w2 ? rows[k][2] : rows[k][1]);
         win[k][1] = pad_px(PAD_MODE, p.w2, rows[k][1], rows[k][2]);
         win[k][3] = pad_px(PAD_MODE, p.e2, rows[k][3], rows[k][2]);
         win[k][4] = pad_px(PAD_MODE, p.e2 | p.e1, rows[k][4], p.e2 ? rows[k][2] : rows[k][3]);
      end
      win_o = win;
   end
endmodule

// File: rtl/conv_kernel_win.sv
// conv_kernel_win: five-column sliding window with flush drain and boundary padding.
module conv_kernel_win
   import conv_pkg::*;
#(
   parameter pad_mode_t PAD_MODE = PAD_ZERO
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4:0]              colD_push_i,
   input  logic [KERNEL_POS_W-1:0] colD_pos_i,
   input  logic [5*PIXEL_W-1:0]    colD_data_i,
   input  logic                    flush_i,
   input  logic                    m_tready_i,
   output logic                    m_tvalid_o,
   output logic [WINDOW_W-1:0]     m_tdata_o,
   output logic [KERNEL_POS_W-1:0] m_tpos_o,
   output logic                    m_tuser_o,
   output logic                    m_tlast_o,
   output logic                    busy_o
);
   win_state_t state_q, state_d;
   col_t [4:0] col_q, col_d;
   logic       sent_q, sent_d;
   logic [1:0] bub_q, bub_d;
   logic       push, shift, bubble, done;
   col_t       in_col;
   window_t    raw;

   always_comb begin
      push = |colD_push_i;
      m_tvalid_o = col_q[2].valid & ~sent_q;
      // bubbles advance only once the current centre has been taken
      bubble = state_q == FLUSH && !bub_q[1] && !m_tvalid_o;
      done = state_q == FLUSH && bub_q[1] && !m_tvalid_o;
      shift = (push && state_q != FLUSH) || bubble;
      in_col = state_q == FLUSH ? '0 : {1'b1, colD_pos_i, colD_data_i};
      col_d = done ? '0 : shift ? {in_col, col_q[4:1]} : col_q;
      sent_d = !shift && (sent_q || (m_tvalid_o && m_tready_i));
      bub_d = state_q == FLUSH ? bub_q + {1'b0, bubble} : 2'd0;
      case (state_q)
         IDLE:    state_d = push ? FILL : IDLE;
         FILL:    state_d = push && col_q[3].valid ? RUN : FILL;
         RUN:     state_d = flush_i ? FLUSH : RUN;
         FLUSH:   state_d = done ? IDLE : FLUSH;
         default: state_d = IDLE;
      endcase
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            raw[i][j] = col_q[j].data[i];
      m_tpos_o = col_q[2].pos;
      m_tuser_o = col_q[2].valid & col_q[2].pos.n2 & col_q[2].pos.w2;
      m_tlast_o = col_q[2].valid & col_q[2].pos.e2;
      busy_o = state_q == FLUSH;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         col_q <= '0;
         sent_q <= 1'b0;
         bub_q <= 2'd0;
      end else begin
         state_q <= state_d;
         col_q <= col_d;
         sent_q <= sent_d;
         bub_q <= bub_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         assert (m_tready_i);
         assert (state_q != FLUSH);
      end
   end

   conv_kernel_win_pad #(.PAD_MODE(PAD_MODE)) u_pad (
      .raw_i(raw),
      .pos_i(m_tpos_o),
      .win_o(m_tdata_o)
   );
endmodule
